// File: rtl/store_unit.sv
// Store unit: decodes D/DS-form stores, computes the effective address, queues valid stores
// in order and drains each one into block memory with a read-modify-write.
module store_unit #(
  parameter int unsigned memoryBlockSize  = 128,
  parameter int unsigned numMemoryBlocks  = 128,
  parameter int unsigned queueDepth       = 4,
  parameter int unsigned addressSize      = 64,
  parameter int unsigned opcodeWidth      = 6,
  parameter int unsigned xOpCodeWidth     = 10,
  parameter int unsigned immWidth         = 16,
  parameter int unsigned regWidth         = 5,
  parameter int unsigned formatIndexRange = 5,
  parameter int unsigned D                = 3,
  parameter int unsigned DS               = 5,
  parameter int unsigned LdStUnitCode     = 2
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                enable_i,
  input  logic [1:0]                          functionalUnitCode_i,
  input  logic [opcodeWidth-1:0]              opCode_i,
  input  logic [xOpCodeWidth-1:0]             xOpCode_i,
  input  logic [formatIndexRange-1:0]         instructionFormat_i,
  input  logic [addressSize-1:0]              operand1_i,
  input  logic [addressSize-1:0]              operand2_i,
  input  logic [regWidth-1:0]                 reg2Address_i,
  input  logic [immWidth-1:0]                 imm_i,
  output logic                                busy_o,
  output logic                                idle_o,
  output logic                                alignmentError_o,
  output logic                                reg2WritebackEnable_o,
  output logic [regWidth-1:0]                 reg2WritebackAddress_o,
  output logic [addressSize-1:0]              reg2WritebackVal_o,
  output logic                                memReadEnable_o,
  output logic                                memWriteEnable_o,
  output logic [$clog2(numMemoryBlocks)-1:0]  memBlockIndex_o,
  input  logic [memoryBlockSize-1:0]          memReadData_i,
  output logic [memoryBlockSize-1:0]          memWriteData_o
);

  localparam int unsigned BlockBytes = memoryBlockSize / 8;
  localparam int unsigned OffW       = $clog2(BlockBytes);
  localparam int unsigned BlkW       = $clog2(numMemoryBlocks);
  localparam int unsigned PtrW       = $clog2(queueDepth);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned SizeW      = 4;

  localparam logic [opcodeWidth-1:0] OpStw  = opcodeWidth'(36);
  localparam logic [opcodeWidth-1:0] OpStwu = opcodeWidth'(37);
  localparam logic [opcodeWidth-1:0] OpStb  = opcodeWidth'(38);
  localparam logic [opcodeWidth-1:0] OpStbu = opcodeWidth'(39);
  localparam logic [opcodeWidth-1:0] OpSth  = opcodeWidth'(44);
  localparam logic [opcodeWidth-1:0] OpSthu = opcodeWidth'(45);
  localparam logic [opcodeWidth-1:0] OpStd  = opcodeWidth'(62);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  // Decode
  logic             st_valid;
  logic             st_update;
  logic             st_ds;
  logic [SizeW-1:0] st_size;

  always_comb begin
    st_valid  = 1'b0;
    st_update = 1'b0;
    st_ds     = 1'b0;
    st_size   = '0;
    if (instructionFormat_i == formatIndexRange'(D)) begin
      case (opCode_i)
        OpStb, OpStbu: begin
          st_valid  = 1'b1;
          st_size   = SizeW'(1);
          st_update = (opCode_i == OpStbu);
        end
        OpSth, OpSthu: begin
          st_valid  = 1'b1;
          st_size   = SizeW'(2);
          st_update = (opCode_i == OpSthu);
        end
        OpStw, OpStwu: begin
          st_valid  = 1'b1;
          st_size   = SizeW'(4);
          st_update = (opCode_i == OpStwu);
        end
        default: ;
      endcase
    end else if (instructionFormat_i == formatIndexRange'(DS) && opCode_i == OpStd) begin
      st_ds = 1'b1;
      if (xOpCode_i == '0) begin
        st_valid = 1'b1;
        st_size  = SizeW'(8);
      end else if (xOpCode_i == xOpCodeWidth'(1)) begin
        st_valid  = 1'b1;
        st_size   = SizeW'(8);
        st_update = 1'b1;
      end
    end
  end

  // Effective address and range/alignment check
  logic [immWidth-1:0]    imm_eff;
  logic [addressSize-1:0] ea;
  logic [OffW-1:0]        ea_off;
  logic                   st_err;
  logic                   presented;
  logic                   accept;

  assign imm_eff = st_ds ? {imm_i[immWidth-1:2], 2'b00} : imm_i;
  assign ea      = operand2_i + {{(addressSize-immWidth){imm_eff[immWidth-1]}}, imm_eff};
  assign ea_off  = ea[OffW-1:0];
  assign st_err  = ((OffW+1)'(ea_off) + (OffW+1)'(st_size) > (OffW+1)'(BlockBytes)) ||
                   (ea[addressSize-1:OffW] >= (addressSize-OffW)'(numMemoryBlocks));

  // A presented store that finds the queue full is dropped without error or writeback.
  assign presented = enable_i && (functionalUnitCode_i == 2'(LdStUnitCode)) && st_valid &&
                     !busy_o;
  assign accept    = presented && !st_err;

  // Store queue
  logic [BlkW-1:0]        q_blk  [queueDepth];
  logic [OffW-1:0]        q_off  [queueDepth];
  logic [SizeW-1:0]       q_size [queueDepth];
  logic [addressSize-1:0] q_data [queueDepth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic            push;
  logic            pop;

  assign push = accept;
  assign pop  = (state_q == StWrite);

  always_ff @(posedge clock_i) begin
    if (push) begin
      q_blk[wr_ptr_q]  <= ea[OffW+BlkW-1:OffW];
      q_off[wr_ptr_q]  <= ea_off;
      q_size[wr_ptr_q] <= st_size;
      q_data[wr_ptr_q] <= operand1_i;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM and block merge
  logic [memoryBlockSize-1:0] rdata_q, rdata_d;
  logic [BlkW-1:0]            head_blk;
  logic [OffW-1:0]            head_off;
  logic [SizeW-1:0]           head_size;
  logic [addressSize-1:0]     head_data;
  logic [SizeW+2:0]           size_sh;
  logic [OffW+2:0]            off_sh;
  logic [addressSize-1:0]     aligned_data;
  logic [addressSize-1:0]     aligned_mask;
  logic [memoryBlockSize-1:0] wide_data;
  logic [memoryBlockSize-1:0] wide_mask;
  logic [memoryBlockSize-1:0] merged;

  assign head_blk  = q_blk[rd_ptr_q];
  assign head_off  = q_off[rd_ptr_q];
  assign head_size = q_size[rd_ptr_q];
  assign head_data = q_data[rd_ptr_q];

  // Left-justify the low size bytes of the data, then shift right to the byte offset;
  // byte 0 of the block sits in the most-significant bits.
  assign size_sh      = {SizeW'(8) - head_size, 3'b000};
  assign off_sh       = {head_off, 3'b000};
  assign aligned_data = head_data << size_sh;
  assign aligned_mask = {addressSize{1'b1}} << size_sh;
  assign wide_data    = {aligned_data, {(memoryBlockSize-addressSize){1'b0}}} >> off_sh;
  assign wide_mask    = {aligned_mask, {(memoryBlockSize-addressSize){1'b0}}} >> off_sh;
  assign merged       = (rdata_q & ~wide_mask) | (wide_data & wide_mask);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle:  if (count_q != '0) state_d = StRead;
      StRead: begin
        rdata_d = memReadData_i;
        state_d = StWrite;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign memReadEnable_o  = (state_q == StIdle) && (count_q != '0);
  assign memWriteEnable_o = (state_q == StWrite);
  assign memBlockIndex_o  = (count_q != '0) ? head_blk : '0;
  assign memWriteData_o   = (state_q == StWrite) ? merged : '0;
  assign busy_o           = (count_q == CntW'(queueDepth));
  assign idle_o           = (count_q == '0) && (state_q == StIdle);

  // Writeback and error pulse
  logic                   wb_en_q, wb_en_d;
  logic [regWidth-1:0]    wb_addr_q, wb_addr_d;
  logic [addressSize-1:0] wb_val_q, wb_val_d;
  logic                   align_err_q, align_err_d;

  always_comb begin
    wb_en_d     = accept && st_update;
    wb_addr_d   = wb_addr_q;
    wb_val_d    = wb_val_q;
    align_err_d = presented && st_err;
    if (accept && st_update) begin
      wb_addr_d = reg2Address_i;
      wb_val_d  = ea;
    end
  end

  assign reg2WritebackEnable_o  = wb_en_q;
  assign reg2WritebackAddress_o = wb_addr_q;
  assign reg2WritebackVal_o     = wb_val_q;
  assign alignmentError_o       = align_err_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      rdata_q     <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_val_q    <= '0;
      align_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_val_q    <= wb_val_d;
      align_err_q <= align_err_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: a block-memory model answers reads, and every write strobe
// is checked in order against a scoreboard filled by a byte-level shadow memory.
module tb_store_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [1:0]   fu;
  logic [5:0]   op;
  logic [9:0]   xop;
  logic [4:0]   fmt;
  logic [63:0]  rs;
  logic [63:0]  ra;
  logic [4:0]   rn;
  logic [15:0]  imm;
  logic         busy_o, idle_o, align_err_o, wb_en_o;
  logic [4:0]   wb_addr_o;
  logic [63:0]  wb_val_o;
  logic         mem_re_o, mem_we_o;
  logic [6:0]   mem_idx_o;
  logic [127:0] mem_rdata;
  logic [127:0] mem_wdata_o;

  always #5 clk = ~clk;

  store_unit dut (
    .clock_i               (clk),
    .reset_i               (rst_n),
    .enable_i              (enable),
    .functionalUnitCode_i  (fu),
    .opCode_i              (op),
    .xOpCode_i             (xop),
    .instructionFormat_i   (fmt),
    .operand1_i            (rs),
    .operand2_i            (ra),
    .reg2Address_i         (rn),
    .imm_i                 (imm),
    .busy_o                (busy_o),
    .idle_o                (idle_o),
    .alignmentError_o      (align_err_o),
    .reg2WritebackEnable_o (wb_en_o),
    .reg2WritebackAddress_o(wb_addr_o),
    .reg2WritebackVal_o    (wb_val_o),
    .memReadEnable_o       (mem_re_o),
    .memWriteEnable_o      (mem_we_o),
    .memBlockIndex_o       (mem_idx_o),
    .memReadData_i         (mem_rdata),
    .memWriteData_o        (mem_wdata_o)
  );

  // Block memory: read data valid the cycle after the request, writes land on the edge.
  logic [127:0] mem [128];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_re_o) mem_rdata <= mem[mem_idx_o];
      if (mem_we_o) mem[mem_idx_o] <= mem_wdata_o;
    end
  end

  typedef struct {
    int           idx;
    logic [127:0] data;
  } wr_t;

  wr_t          sb[$];
  logic [127:0] shadow [128];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           wr_cyc   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle; any write strobe seen is compared against the scoreboard head.
  task automatic tick();
    logic have;
    wr_t  e;
    @(negedge clk);
    cyc++;
    if (mem_we_o === 1'b1) begin
      wr_cyc = cyc;
      have   = (sb.size() != 0);
      chk("write_was_expected", 128'(have), 128'd1);
      if (have) begin
        e = sb.pop_front();
        chk("write_index", 128'(mem_idx_o), 128'(e.idx));
        chk("write_data", mem_wdata_o, e.data);
      end
    end
  endtask

  function automatic logic [63:0] calc_ea(input logic [63:0] a, input logic [15:0] i,
                                          input bit ds);
    logic [15:0] ie;
    ie = ds ? (i & 16'hFFFC) : i;
    return a + {{48{ie[15]}}, ie};
  endfunction

  task automatic expect_store(input logic [63:0] ea, input int size, input logic [63:0] d);
    int idx, off;
    idx = int'(ea >> 4);
    off = int'(ea[3:0]);
    for (int k = 0; k < size; k++)
      shadow[idx][127-8*(off+k) -: 8] = d[8*(size-1-k) +: 8];
    sb.push_back('{idx, shadow[idx]});
  endtask

  // Drive one instruction for one cycle; returns at the negedge after the sampling edge.
  task automatic st(input logic [5:0] o, input logic [9:0] x, input logic [4:0] f,
                    input logic [63:0] d, input logic [63:0] a, input logic [15:0] i,
                    input logic [4:0] r, input int size, input bit exp_acc);
    if (exp_acc) expect_store(calc_ea(a, i, f == 5'd5), size, d);
    enable = 1'b1; op = o; xop = x; fmt = f; rs = d; ra = a; imm = i; rn = r;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && !(idle_o === 1'b1 && sb.size() == 0); i++) tick();
    chk({tag, "_idle"}, 128'(idle_o), 128'd1);
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
  endtask

  int acc_cyc;

  initial begin
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    rst_n = 1'b0; enable = 1'b0; fu = 2'd2; op = '0; xop = '0; fmt = '0;
    rs = '0; ra = '0; imm = '0; rn = '0;
    repeat (2) tick();
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_wdata", mem_wdata_o, 128'd0);
    chk("rst_we", 128'(mem_we_o), 128'd0);
    chk("rst_wb_val", 128'(wb_val_o), 128'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle", 128'(idle_o), 128'd1);

    // stb at EA 0x13: one byte at block 1 byte 3, write three cycles after acceptance
    st(6'd38, 10'd0, 5'd3, 64'h0000_0000_0000_00AB, 64'h10, 16'h0003, 5'd0, 1, 1'b1);
    acc_cyc = cyc - 1;
    chk("stb_no_wb", 128'(wb_en_o), 128'd0);
    chk("stb_read_req", 128'(mem_re_o), 128'd1);
    wait_drain("stb");
    chk("stb_latency", 128'(wr_cyc - acc_cyc), 128'd3);
    chk("stb_block1", mem[1], 128'h0000_00AB_0000_0000_0000_0000_0000_0000);

    // sthu with negative displacement, writeback of EA for exactly one cycle
    st(6'd45, 10'd0, 5'd3, 64'h1234, 64'h20, 16'hFFFE, 5'd7, 2, 1'b1);
    chk("sthu_wb_en", 128'(wb_en_o), 128'd1);
    chk("sthu_wb_addr", 128'(wb_addr_o), 128'd7);
    chk("sthu_wb_val", 128'(wb_val_o), 128'h1E);
    tick();
    chk("sthu_wb_pulse", 128'(wb_en_o), 128'd0);
    chk("sthu_wb_hold", 128'(wb_val_o), 128'h1E);
    wait_drain("sthu");
    chk("sthu_block1", mem[1], 128'h0000_00AB_0000_0000_0000_0000_0000_1234);

    // Misaligned stw and out-of-range std: one error pulse each, no memory activity
    st(6'd36, 10'd0, 5'd3, 64'hDEAD_BEEF, 64'h0E, 16'h0000, 5'd0, 4, 1'b0);
    chk("stw_err_pulse", 128'(align_err_o), 128'd1);
    chk("stw_err_no_read", 128'(mem_re_o), 128'd0);
    chk("stw_err_idle", 128'(idle_o), 128'd1);
    tick();
    chk("stw_err_once", 128'(align_err_o), 128'd0);
    st(6'd62, 10'd0, 5'd5, 64'h1, 64'h800, 16'h0000, 5'd0, 8, 1'b0);
    chk("std_oob_pulse", 128'(align_err_o), 128'd1);
    chk("std_oob_idle", 128'(idle_o), 128'd1);
    tick();
    chk("std_oob_once", 128'(align_err_o), 128'd0);

    // stdu at offset 8 (fills to the end of the block); low imm bits are ignored
    st(6'd62, 10'd1, 5'd5, 64'h0102_0304_0506_0708, 64'h38, 16'h0003, 5'd9, 8, 1'b1);
    chk("stdu_no_err", 128'(align_err_o), 128'd0);
    chk("stdu_wb_val", 128'(wb_val_o), 128'h38);
    chk("stdu_wb_addr", 128'(wb_addr_o), 128'd9);
    wait_drain("stdu");
    chk("stdu_block3", mem[3], 128'h0000_0000_0000_0000_0102_0304_0506_0708);

    // Last byte of the last block is legal
    st(6'd38, 10'd0, 5'd3, 64'h5A, 64'h7F0, 16'h000F, 5'd0, 1, 1'b1);
    chk("last_byte_no_err", 128'(align_err_o), 128'd0);
    wait_drain("last_byte");
    chk("last_byte_block127", mem[127], 128'h5A);

    // Wrong unit code and wrong format are ignored silently
    fu = 2'd1;
    enable = 1'b1; op = 6'd38; fmt = 5'd3; ra = 64'h50; imm = '0; rs = 64'h77;
    tick();
    enable = 1'b0; fu = 2'd2;
    chk("fu_mismatch_idle", 128'(idle_o), 128'd1);
    st(6'd38, 10'd0, 5'd5, 64'h77, 64'h50, 16'h0000, 5'd0, 1, 1'b0);
    chk("bad_fmt_idle", 128'(idle_o), 128'd0 + 128'(1));
    chk("bad_fmt_no_err", 128'(align_err_o), 128'd0);

    // Back-to-back stw: queue fills on the fifth, the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("busy_before_%0d", i), 128'(busy_o), 128'(i == 5));
      st(6'd36, 10'd0, 5'd3, 64'hC0DE_0000 + 64'(i), 64'hA0 + 64'(i) * 16, 16'h0004, 5'd0,
         4, i < 5);
    end
    wait_drain("burst");
    chk("burst_dropped_block15", mem[15], 128'd0);
    chk("burst_block14", mem[14], 128'h0000_0000_C0DE_0004_0000_0000_0000_0000);

    // Two stores to one block commit in order
    st(6'd38, 10'd0, 5'd3, 64'h11, 64'h40, 16'h0000, 5'd0, 1, 1'b1);
    st(6'd38, 10'd0, 5'd3, 64'h22, 64'h41, 16'h0000, 5'd0, 1, 1'b1);
    wait_drain("same_block");
    chk("same_block4", mem[4], 128'h1122_0000_0000_0000_0000_0000_0000_0000);

    // Reset while the RMW is in READ: the write is abandoned
    st(6'd36, 10'd0, 5'd3, 64'h99887766, 64'h20, 16'h0000, 5'd0, 4, 1'b0);
    chk("rmw_read_req", 128'(mem_re_o), 128'd1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rmw_rst_we", 128'(mem_we_o), 128'd0);
    chk("rmw_rst_re", 128'(mem_re_o), 128'd0);
    chk("rmw_rst_idx", 128'(mem_idx_o), 128'd0);
    chk("rmw_rst_wdata", mem_wdata_o, 128'd0);
    chk("rmw_rst_wb", 128'({wb_en_o, wb_addr_o, wb_val_o}), 128'd0);
    chk("rmw_rst_busy_err", 128'({busy_o, align_err_o}), 128'd0);
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rmw_after_idle", 128'(idle_o), 128'd1);
    chk("rmw_after_block2", mem[2], 128'd0);
    st(6'd44, 10'd0, 5'd3, 64'hBEEF, 64'h20, 16'h0004, 5'd0, 2, 1'b1);
    wait_drain("post_reset");
    chk("post_reset_block2", mem[2], 128'h0000_0000_BEEF_0000_0000_0000_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
